// File: rtl/adc_test_pkg.sv
// Shared definitions for the ADC capture front-end: capture state encoding
// and default widths.
package adc_test_pkg;

  localparam int unsigned DEFAULT_PRECISION   = 10;
  localparam int unsigned DEFAULT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_capture_ctrl_sync_pulse.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector that yields a one-cycle pulse in the clk domain.
module sync_pulse #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    level_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~level_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture front-end: registers raw codes, waits for a host arm and an
// optional threshold crossing, then writes decimated samples to the FIFO.
module adc_capture_ctrl
  import adc_test_pkg::*;
#(
  parameter int unsigned PRECISION   = DEFAULT_PRECISION,
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int unsigned DECIM_WIDTH = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   adc_clk,
  input  logic                   rst,
  input  logic [PRECISION-1:0]   adc_code_in,
  input  logic                   arm_async,
  input  logic                   abort_async,
  input  logic                   trig_mode,
  input  logic [PRECISION-1:0]   trig_level,
  input  logic [DECIM_WIDTH-1:0] decim,
  input  logic [COUNT_WIDTH-1:0] num_samples,
  input  logic                   fifo_full,
  output logic [PRECISION-1:0]   fifo_din,
  output logic                   fifo_wr_en,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [COUNT_WIDTH-1:0] drop_count,
  output logic [COUNT_WIDTH-1:0] wr_count
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [DECIM_WIDTH-1:0] DEC_ONE = 1;

  logic arm_p, abort_p;

  sync_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_arm_sync (
    .clk(adc_clk), .rst(rst), .async_in(arm_async), .pulse(arm_p)
  );

  sync_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_abort_sync (
    .clk(adc_clk), .rst(rst), .async_in(abort_async), .pulse(abort_p)
  );

  cap_state_e             state_q, state_d;
  logic [PRECISION-1:0]   code_q, code_d, code_prev_q, code_prev_d;
  logic [PRECISION-1:0]   trig_level_q, trig_level_d;
  logic [DECIM_WIDTH-1:0] decim_q, decim_d, dec_cnt_q, dec_cnt_d;
  logic [COUNT_WIDTH-1:0] num_q, num_d, kept_q, kept_d;
  logic [PRECISION-1:0]   fifo_din_q, fifo_din_d;
  logic                   fifo_wr_en_q, fifo_wr_en_d;
  logic                   done_q, done_d, aborted_q, aborted_d;
  logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d, wr_count_q, wr_count_d;
  logic                   trig_hit, take_sample;
  logic [COUNT_WIDTH-1:0] kept_inc;

  always_comb begin
    code_d       = adc_code_in;
    code_prev_d  = code_q;
    state_d      = state_q;
    trig_level_d = trig_level_q;
    decim_d      = decim_q;
    num_d        = num_q;
    dec_cnt_d    = dec_cnt_q;
    kept_d       = kept_q;
    fifo_din_d   = fifo_din_q;
    fifo_wr_en_d = 1'b0;
    done_d       = done_q;
    aborted_d    = aborted_q;
    drop_count_d = drop_count_q;
    wr_count_d   = wr_count_q;
    trig_hit     = (code_prev_q < trig_level_q) && (code_q >= trig_level_q);
    // The triggering sample is processed in the same cycle the trigger fires.
    take_sample  = (state_q == CAPTURE) || ((state_q == WAIT_TRIG) && trig_hit);
    kept_inc     = kept_q + CNT_ONE;

    if (abort_p && ((state_q != IDLE) || arm_p)) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else if (arm_p && ((state_q == IDLE) || (state_q == DONE))) begin
      trig_level_d = trig_level;
      decim_d      = decim;
      num_d        = num_samples;
      dec_cnt_d    = '0;
      kept_d       = '0;
      done_d       = 1'b0;
      aborted_d    = 1'b0;
      wr_count_d   = '0;
      drop_count_d = '0;
      if (num_samples == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = trig_mode ? WAIT_TRIG : CAPTURE;
      end
    end else if (take_sample) begin
      state_d   = CAPTURE;
      dec_cnt_d = (dec_cnt_q == decim_q) ? '0 : dec_cnt_q + DEC_ONE;
      if (dec_cnt_q == '0) begin
        kept_d = kept_inc;
        if (!fifo_full) begin
          fifo_wr_en_d = 1'b1;
          fifo_din_d   = code_q;
          wr_count_d   = wr_count_q + CNT_ONE;
        end else if (drop_count_q != '1) begin
          drop_count_d = drop_count_q + CNT_ONE;
        end
        if (kept_inc == num_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= '0;
      code_prev_q  <= '0;
      trig_level_q <= '0;
      decim_q      <= '0;
      num_q        <= '0;
      dec_cnt_q    <= '0;
      kept_q       <= '0;
      fifo_din_q   <= '0;
      fifo_wr_en_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      drop_count_q <= '0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      code_prev_q  <= code_prev_d;
      trig_level_q <= trig_level_d;
      decim_q      <= decim_d;
      num_q        <= num_d;
      dec_cnt_q    <= dec_cnt_d;
      kept_q       <= kept_d;
      fifo_din_q   <= fifo_din_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      drop_count_q <= drop_count_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign fifo_din   = fifo_din_q;
  assign fifo_wr_en = fifo_wr_en_q;
  assign busy       = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign drop_count = drop_count_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: directed scenarios plus random
// captures, all compared every cycle against a sample-index reference model.
module tb_adc_capture_ctrl;

  localparam int unsigned P = 10;
  localparam int unsigned C = 16;
  localparam int unsigned D = 8;
  localparam int unsigned S = 2;
  localparam int DROP_MAX = (1 << C) - 1;

  logic         adc_clk = 1'b0;
  logic         rst = 1'b1;
  logic [P-1:0] adc_code_in = '0;
  logic         arm_async = 1'b0;
  logic         abort_async = 1'b0;
  logic         trig_mode = 1'b0;
  logic [P-1:0] trig_level = '0;
  logic [D-1:0] decim = '0;
  logic [C-1:0] num_samples = '0;
  logic         fifo_full = 1'b0;
  logic [P-1:0] fifo_din;
  logic         fifo_wr_en, busy, done, aborted;
  logic [C-1:0] drop_count, wr_count;

  adc_capture_ctrl #(
    .PRECISION(P), .COUNT_WIDTH(C), .DECIM_WIDTH(D), .SYNC_STAGES(S)
  ) dut (
    .adc_clk(adc_clk), .rst(rst), .adc_code_in(adc_code_in),
    .arm_async(arm_async), .abort_async(abort_async), .trig_mode(trig_mode),
    .trig_level(trig_level), .decim(decim), .num_samples(num_samples),
    .fifo_full(fifo_full), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .busy(busy), .done(done), .aborted(aborted), .drop_count(drop_count),
    .wr_count(wr_count)
  );

  always #5 adc_clk = ~adc_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: capture session described by sample index since start.
  bit arm_h[$], abort_h[$];
  int m_cur, m_prev, m_din, m_wr, m_drop, m_kept, m_idx, m_n, m_dec, m_lvl;
  bit m_active, m_waiting, m_finished, m_done, m_aborted, m_wr_en;

  int pin_mode, ramp_v, hold_v, full_mode;
  logic [P-1:0] obs_q[$];

  task automatic model_reset();
    arm_h.delete(); abort_h.delete();
    for (int i = 0; i < S + 2; i++) begin arm_h.push_back(1'b0); abort_h.push_back(1'b0); end
    m_cur = 0; m_prev = 0; m_din = 0; m_wr = 0; m_drop = 0; m_kept = 0; m_idx = 0;
    m_n = 0; m_dec = 0; m_lvl = 0;
    m_active = 0; m_waiting = 0; m_finished = 0; m_done = 0; m_aborted = 0; m_wr_en = 0;
  endtask

  task automatic model_step();
    bit a_p, ab_p;
    arm_h.push_front(arm_async);     void'(arm_h.pop_back());
    abort_h.push_front(abort_async); void'(abort_h.pop_back());
    a_p  = arm_h[S] && !arm_h[S+1];
    ab_p = abort_h[S] && !abort_h[S+1];
    m_wr_en = 0;
    if (ab_p && (m_active || m_finished || a_p)) begin
      m_aborted = 1; m_active = 0; m_finished = 0; m_waiting = 0;
    end else if (a_p && !m_active) begin
      m_lvl = trig_level; m_dec = decim; m_n = num_samples;
      m_done = 0; m_aborted = 0; m_wr = 0; m_drop = 0; m_kept = 0; m_idx = 0;
      if (m_n == 0) begin m_finished = 1; m_done = 1; end
      else begin m_finished = 0; m_active = 1; m_waiting = trig_mode; end
    end else if (m_active && (!m_waiting || (m_prev < m_lvl && m_cur >= m_lvl))) begin
      m_waiting = 0;
      if (m_idx % (m_dec + 1) == 0) begin
        m_kept++;
        if (!fifo_full) begin m_wr_en = 1; m_din = m_cur; m_wr++; end
        else if (m_drop < DROP_MAX) m_drop++;
        if (m_kept == m_n) begin m_active = 0; m_finished = 1; m_done = 1; end
      end
      m_idx++;
    end
    m_prev = m_cur;
    m_cur  = adc_code_in;
  endtask

  task automatic check_outputs();
    chk_eq("wr_en", fifo_wr_en, m_wr_en);
    chk_eq("din", fifo_din, m_din);
    chk_eq("busy", busy, m_active);
    chk_eq("done", done, m_done);
    chk_eq("aborted", aborted, m_aborted);
    chk_eq("drop_count", drop_count, m_drop);
    chk_eq("wr_count", wr_count, m_wr);
    if (fifo_wr_en === 1'b1) obs_q.push_back(fifo_din);
  endtask

  task automatic drive();
    case (pin_mode)
      0: begin adc_code_in = P'(ramp_v); ramp_v++; end
      1: adc_code_in = P'(hold_v);
      default: adc_code_in = P'($urandom_range(0, (1 << P) - 1));
    endcase
    case (full_mode)
      0: fifo_full = 1'b0;
      1: fifo_full = ($urandom_range(0, 3) == 0);
      default: fifo_full = m_active && !m_waiting && m_kept >= 3 && m_kept <= 5;
    endcase
  endtask

  task automatic cycle();
    @(posedge adc_clk);
    if (rst) model_reset(); else model_step();
    @(negedge adc_clk);
    check_outputs();
    drive();
  endtask

  task automatic do_arm(input bit mode, input int lvl, input int dec, input int n);
    arm_async = 1'b0;
    repeat (S + 2) cycle();
    trig_mode = mode; trig_level = P'(lvl); decim = D'(dec); num_samples = C'(n);
    arm_async = 1'b1;
    repeat (S + 2) cycle();
    arm_async = 1'b0;
    trig_mode = 1'($urandom); trig_level = P'($urandom);
    decim = D'($urandom); num_samples = C'($urandom);
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n = 0;
    bit timed_out;
    while (busy === 1'b1 && n < budget) begin cycle(); n++; end
    timed_out = (busy !== 1'b0);
    chk_eq({tag, "_timeout"}, timed_out, 1'b0);
    cycle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    pin_mode = 0; ramp_v = 0; hold_v = 0; full_mode = 0;
    repeat (3) cycle();
    rst = 1'b0;

    // 1: immediate capture of a ramp
    ramp_v = 0; obs_q.delete();
    do_arm(0, 0, 0, 8);
    run_idle(100, "t1");
    chk_eq("t1_wr_count", wr_count, 8);
    chk_eq("t1_done", done, 1);
    chk_eq("t1_drop", drop_count, 0);
    chk_eq("t1_nwrites", obs_q.size(), 8);
    for (int i = 0; i + 1 < obs_q.size(); i++) chk_eq("t1_step", obs_q[i+1] - obs_q[i], 1);

    // 2: decimation by 4
    obs_q.delete();
    do_arm(0, 0, 3, 4);
    run_idle(100, "t2");
    chk_eq("t2_done", done, 1);
    chk_eq("t2_nwrites", obs_q.size(), 4);
    for (int i = 0; i + 1 < obs_q.size(); i++) chk_eq("t2_step", obs_q[i+1] - obs_q[i], 4);

    // 3: threshold trigger, including an exact-level crossing and a pre-armed high level
    pin_mode = 1; hold_v = 100; obs_q.delete();
    do_arm(1, 512, 0, 4);
    repeat (10) cycle();
    chk_eq("t3_waiting", busy, 1);
    chk_eq("t3_no_write", wr_count, 0);
    hold_v = 600;
    run_idle(100, "t3");
    chk_eq("t3_first", obs_q.size() > 0 ? obs_q[0] : 0, 600);
    hold_v = 700;
    do_arm(1, 512, 0, 2);
    repeat (10) cycle();
    chk_eq("t3_high_no_trig", wr_count, 0);
    chk_eq("t3_high_busy", busy, 1);
    hold_v = 511;
    repeat (3) cycle();
    hold_v = 512; obs_q.delete();
    run_idle(100, "t3b");
    chk_eq("t3b_wr_count", wr_count, 2);
    chk_eq("t3b_first", obs_q.size() > 0 ? obs_q[0] : 0, 512);

    // 4: backpressure during kept samples 4..6
    pin_mode = 0; full_mode = 2;
    do_arm(0, 0, 0, 10);
    run_idle(100, "t4");
    full_mode = 0;
    chk_eq("t4_wr_count", wr_count, 7);
    chk_eq("t4_drop", drop_count, 3);
    chk_eq("t4_done", done, 1);

    // 5: abort after five writes, then a clean restart
    do_arm(0, 0, 0, 20);
    for (int k = 0; k < 50 && m_wr < 5 - int'(S); k++) cycle();
    abort_async = 1'b1;
    repeat (S + 2) cycle();
    chk_eq("t5_wr_en", fifo_wr_en, 0);
    chk_eq("t5_aborted", aborted, 1);
    chk_eq("t5_done", done, 0);
    chk_eq("t5_wr_count", wr_count, 5);
    abort_async = 1'b0;
    do_arm(0, 0, 0, 3);
    chk_eq("t5_restart_aborted", aborted, 0);
    run_idle(100, "t5");
    chk_eq("t5_restart_wr", wr_count, 3);

    // 6: edge cases
    obs_q.delete();
    do_arm(0, 0, 0, 0);
    repeat (2) cycle();
    chk_eq("t6_zero_done", done, 1);
    chk_eq("t6_zero_writes", obs_q.size(), 0);

    do_arm(0, 0, 0, 30);
    repeat (3) cycle();
    num_samples = 5; arm_async = 1'b1;
    repeat (S + 2) cycle();
    arm_async = 1'b0;
    run_idle(200, "t6_busy_arm");
    chk_eq("t6_busy_arm_wr", wr_count, 30);

    repeat (S + 2) cycle();
    num_samples = 5; trig_mode = 1'b0;
    arm_async = 1'b1; abort_async = 1'b1;
    repeat (S + 3) cycle();
    arm_async = 1'b0; abort_async = 1'b0;
    chk_eq("t6_both_aborted", aborted, 1);
    chk_eq("t6_both_busy", busy, 0);

    do_arm(0, 0, 0, 40);
    repeat (5) cycle();
    #2 rst = 1'b1;
    #1;
    chk_eq("t6_rst_wr_en", fifo_wr_en, 0);
    chk_eq("t6_rst_busy", busy, 0);
    chk_eq("t6_rst_wr_count", wr_count, 0);
    chk_eq("t6_rst_din", fifo_din, 0);
    chk_eq("t6_rst_done", done | aborted, 0);
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Random captures with random codes, backpressure and occasional aborts
    for (int it = 0; it < 10; it++) begin
      int abort_at;
      pin_mode = 2; full_mode = 1;
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
      do_arm(1'($urandom), $urandom_range(0, (1 << P) - 1), $urandom_range(0, 3),
             $urandom_range(0, 12));
      for (int k = 0; k < 150 && busy === 1'b1; k++) begin
        if (k == abort_at) abort_async = 1'b1;
        cycle();
      end
      abort_async = 1'b1;
      repeat (S + 2) cycle();
      abort_async = 1'b0;
      repeat (S + 2) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
